// File: rtl/sha3_absorb_pad.sv
// SHA3 message-input stage: packs 64-bit little-endian lanes into rate blocks,
// applies pad10*1 with domain bits 0x06 and hands each block to the permutation.
module sha3_absorb_pad #(
    parameter int RATE_WORDS = 17,
    parameter int LANE_W     = 64
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [LANE_W-1:0]            MSG_IN,
    input  logic                         MSG_VALID,
    input  logic                         MSG_LAST,
    input  logic [3:0]                   MSG_BYTES,
    output logic                         MSG_READY,
    output logic [RATE_WORDS*LANE_W-1:0] BLOCK_OUT,
    output logic                         BLOCK_VALID,
    output logic                         BLOCK_FINAL,
    input  logic                         BLOCK_READY
);

    localparam int BLK_W = RATE_WORDS * LANE_W;
    localparam int CNT_W = $clog2(RATE_WORDS);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATE_WORDS - 1);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_OUT  = 1'b1;

    // Block that carries only padding, used when the message ended on a full block.
    localparam logic [BLK_W-1:0] PAD_BLOCK = {8'h80, {(BLK_W-16){1'b0}}, 8'h06};

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BLK_W-1:0] buf_q, buf_d;
    logic             pad_pending_q, pad_pending_d;
    logic             final_q, final_d;

    logic [3:0]        nb;
    logic [LANE_W-1:0] word;
    logic              accept;

    function automatic logic [LANE_W-1:0] keep_bytes(input logic [LANE_W-1:0] w,
                                                     input logic [3:0]        n);
        logic [LANE_W-1:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < n) r[8*k +: 8] = w[8*k +: 8];
        end
        return r;
    endfunction

    assign MSG_READY   = (state_q == S_FILL) & ~RST;
    assign BLOCK_VALID = (state_q == S_OUT);
    assign BLOCK_FINAL = final_q;
    assign BLOCK_OUT   = buf_q;

    always_comb begin
        nb            = (MSG_BYTES > 4'd8) ? 4'd8 : MSG_BYTES;
        word          = MSG_LAST ? keep_bytes(MSG_IN, nb) : MSG_IN;
        accept        = MSG_READY & MSG_VALID;
        state_d       = state_q;
        cnt_d         = cnt_q;
        buf_d         = buf_q;
        pad_pending_d = pad_pending_q;
        final_d       = final_q;

        if (accept) begin
            buf_d[cnt_q*LANE_W +: LANE_W] = word;
            if (!MSG_LAST) begin
                if (cnt_q != LAST_LANE) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = S_OUT;
                    final_d = 1'b0;
                    cnt_d   = '0;
                end
            end else begin
                state_d = S_OUT;
                cnt_d   = '0;
                if (nb != 4'd8) begin
                    // Domain byte follows the last message byte; may share byte 7 with 0x80.
                    buf_d[cnt_q*LANE_W +: LANE_W] = buf_d[cnt_q*LANE_W +: LANE_W]
                                                  ^ (LANE_W'(8'h06) << {nb[2:0], 3'b000});
                    buf_d[BLK_W-1 -: 8] = buf_d[BLK_W-1 -: 8] ^ 8'h80;
                    final_d = 1'b1;
                end else if (cnt_q != LAST_LANE) begin
                    buf_d[(cnt_q + CNT_W'(1))*LANE_W +: 8] = 8'h06;
                    buf_d[BLK_W-1 -: 8] = buf_d[BLK_W-1 -: 8] ^ 8'h80;
                    final_d = 1'b1;
                end else begin
                    final_d       = 1'b0;
                    pad_pending_d = 1'b1;
                end
            end
        end else if ((state_q == S_OUT) && BLOCK_READY) begin
            if (pad_pending_q) begin
                buf_d         = PAD_BLOCK;
                final_d       = 1'b1;
                pad_pending_d = 1'b0;
            end else begin
                buf_d   = '0;
                cnt_d   = '0;
                final_d = 1'b0;
                state_d = S_FILL;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_FILL;
            cnt_q         <= '0;
            buf_q         <= '0;
            pad_pending_q <= 1'b0;
            final_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            buf_q         <= buf_d;
            pad_pending_q <= pad_pending_d;
            final_q       <= final_d;
        end
    end

endmodule

// File: tb/tb_sha3_absorb_pad.sv
// Directed bench for sha3_absorb_pad: expected blocks are queued when a message
// is sent and compared when the block is handed over.
module tb_sha3_absorb_pad;

    localparam int RW = 17;
    localparam int BW = RW * 64;

    typedef struct {
        logic [BW-1:0] blk;
        logic          fin;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [63:0]   MSG_IN = '0;
    logic          MSG_VALID = 1'b0;
    logic          MSG_LAST = 1'b0;
    logic [3:0]    MSG_BYTES = '0;
    logic          MSG_READY;
    logic [BW-1:0] BLOCK_OUT;
    logic          BLOCK_VALID;
    logic          BLOCK_FINAL;
    logic          BLOCK_READY = 1'b0;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    sha3_absorb_pad #(.RATE_WORDS(RW), .LANE_W(64)) dut (
        .CLK(CLK), .RST(RST),
        .MSG_IN(MSG_IN), .MSG_VALID(MSG_VALID), .MSG_LAST(MSG_LAST),
        .MSG_BYTES(MSG_BYTES), .MSG_READY(MSG_READY),
        .BLOCK_OUT(BLOCK_OUT), .BLOCK_VALID(BLOCK_VALID),
        .BLOCK_FINAL(BLOCK_FINAL), .BLOCK_READY(BLOCK_READY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [BW-1:0] lane(input int i, input logic [63:0] v);
        logic [BW-1:0] r;
        r = '0;
        r[i*64 +: 64] = v;
        return r;
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        int bad;
        checks++;
        assert (obs === exp) else begin
            errors++;
            bad = 0;
            for (int i = RW - 1; i >= 0; i--)
                if (obs[i*64 +: 64] !== exp[i*64 +: 64]) bad = i;
            $error("FAIL %s lane %0d observed=%h expected=%h", tag, bad,
                   obs[bad*64 +: 64], exp[bad*64 +: 64]);
        end
    endtask

    task automatic push(input logic [BW-1:0] blk, input logic fin);
        exp_t e;
        e.blk = blk;
        e.fin = fin;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int n = 0;
        while (MSG_READY !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check1("msg_ready_wait", MSG_READY, 1'b1);
        MSG_IN    = d;
        MSG_LAST  = last;
        MSG_BYTES = nb;
        MSG_VALID = 1'b1;
        tick();
        MSG_VALID = 1'b0;
        MSG_LAST  = 1'b0;
    endtask

    task automatic recv(input string tag);
        exp_t e;
        int   n = 0;
        while (BLOCK_VALID !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check1({tag, "_valid"}, BLOCK_VALID, 1'b1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty, observed a block with expected none", tag);
        end else begin
            e = sb.pop_front();
            chk_blk({tag, "_block"}, BLOCK_OUT, e.blk);
            check1({tag, "_final"}, BLOCK_FINAL, e.fin);
        end
        BLOCK_READY = 1'b1;
        tick();
        BLOCK_READY = 1'b0;
    endtask

    logic [BW-1:0] empty_blk;
    logic [BW-1:0] blk;

    initial begin
        empty_blk = lane(0, 64'h06) | lane(RW - 1, 64'h8000000000000000);

        // reset state
        tick();
        tick();
        check1("rst_msg_ready", MSG_READY, 1'b0);
        check1("rst_block_valid", BLOCK_VALID, 1'b0);
        check1("rst_block_final", BLOCK_FINAL, 1'b0);
        chk_blk("rst_block_out", BLOCK_OUT, '0);
        RST = 1'b0;
        tick();
        check1("post_rst_msg_ready", MSG_READY, 1'b1);

        // empty message
        push(empty_blk, 1'b1);
        send_word(64'h0, 1'b1, 4'd0);
        check1("empty_latency", BLOCK_VALID, 1'b1);
        check1("empty_ready_low", MSG_READY, 1'b0);
        recv("empty");
        check1("empty_ready_after", MSG_READY, 1'b1);

        // "abc"
        push(lane(0, 64'h0000000006636261) | lane(RW - 1, 64'h8000000000000000), 1'b1);
        send_word(64'h0000000000636261, 1'b1, 4'd3);
        recv("abc");

        // exact rate: full block then pad-only block
        blk = '0;
        for (int i = 0; i < RW; i++) blk = blk | lane(i, 64'(i + 1));
        push(blk, 1'b0);
        push(empty_blk, 1'b1);
        for (int i = 0; i < RW; i++) begin
            send_word(64'(i + 1), (i == RW - 1), 4'd8);
            if (i == 0) check1("exact_not_early", BLOCK_VALID, 1'b0);
        end
        check1("exact_latency", BLOCK_VALID, 1'b1);
        recv("exact_first");
        check1("exact_gap_ready", MSG_READY, 1'b0);
        check1("exact_pad_valid", BLOCK_VALID, 1'b1);
        recv("exact_pad");
        check1("exact_ready_after", MSG_READY, 1'b1);

        // shared pad byte; top message byte must be masked off
        blk = '0;
        for (int i = 0; i < RW - 1; i++) blk = blk | lane(i, 64'h1000 + 64'(i));
        blk = blk | lane(RW - 1, 64'h86FFFFFFFFFFFFFF);
        push(blk, 1'b1);
        for (int i = 0; i < RW - 1; i++) send_word(64'h1000 + 64'(i), 1'b0, 4'd8);
        send_word(64'hAAFFFFFFFFFFFFFF, 1'b1, 4'd7);
        recv("shared");

        // MSG_BYTES above 8 behaves as 8 with room left in the block
        push(lane(0, 64'hDEADBEEF01234567) | lane(1, 64'h06) |
             lane(RW - 1, 64'h8000000000000000), 1'b1);
        send_word(64'hDEADBEEF01234567, 1'b1, 4'd15);
        recv("clamp");

        // backpressure with partial last word
        blk = lane(0, 64'h0000000000066768) | lane(RW - 1, 64'h8000000000000000);
        push(blk, 1'b1);
        send_word(64'h1122334455666768, 1'b1, 4'd2);
        for (int c = 0; c < 5; c++) begin
            chk_blk("bp_hold_block", BLOCK_OUT, blk);
            check1("bp_hold_final", BLOCK_FINAL, 1'b1);
            check1("bp_hold_ready", MSG_READY, 1'b0);
            tick();
        end
        recv("bp");
        check1("bp_ready_after", MSG_READY, 1'b1);

        // reset mid-fill discards partial data
        for (int i = 0; i < 5; i++) send_word(64'hFFFF0000FFFF0000 ^ 64'(i), 1'b0, 4'd0);
        RST = 1'b1;
        tick();
        check1("midrst_msg_ready", MSG_READY, 1'b0);
        check1("midrst_block_valid", BLOCK_VALID, 1'b0);
        RST = 1'b0;
        push(empty_blk, 1'b1);
        send_word(64'h0, 1'b1, 4'd0);
        recv("midrst_empty");

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
